// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared mips32 register-file types and constants
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/mips_regfile_mp_if.sv
// rtl/mips_regfile_mp_if.sv - decode/writeback bus of the multi-port register file
interface mips_regfile_mp_if
  import mips_pkg::*;
#(
  parameter int DW  = REG_DW,
  parameter int AW  = REG_AW,
  parameter int NRD = 2,
  parameter int NWR = 2
) ();

  logic [NWR-1:0]    we;
  logic [NWR*AW-1:0] wa;
  logic [NWR*DW-1:0] wd;
  logic [NRD-1:0]    re;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    rbusy;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic [2**AW-1:0]  busy_vec;

  modport master (
    output we, wa, wd, re, ra, alloc_en, alloc_addr,
    input  rd, rbusy, busy_vec
  );

  modport slave (
    input  we, wa, wd, re, ra, alloc_en, alloc_addr,
    output rd, rbusy, busy_vec
  );

endinterface

// File: rtl/mips_rf_rdport.sv
// rtl/mips_rf_rdport.sv - one read port: zero-register, bypass mux, busy masking (REGFILE_BYPASS_EN)
module mips_rf_rdport
  import mips_pkg::*;
#(
  parameter int DW      = REG_DW,
  parameter int AW      = REG_AW,
  parameter int NWR     = 2,
  parameter int R0_ZERO = 1
) (
  input  logic              re,
  input  logic [AW-1:0]     ra,
  input  logic [DW-1:0]     arr_rdata,
  input  logic              arr_busy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] wd,
  output logic [DW-1:0]     rd,
  output logic              rbusy
);

`ifndef REGFILE_BYPASS_EN
  // Write-port inputs are only consumed by the forwarding path.
  logic unused_wr_ok;
  assign unused_wr_ok = ^{we, wa, wd};
`endif

  // Priority: disabled port, hard-wired zero, same-cycle forward (highest port last), array.
  always_comb begin
    rd    = '0;
    rbusy = 1'b0;
    if (re && !((R0_ZERO != 0) && (ra == AW'(REG_ZERO)))) begin
      rd    = arr_rdata;
      rbusy = arr_busy;
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (wa[k*AW +: AW] == ra)) begin
          rd    = wd[k*DW +: DW];
          rbusy = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// rtl/mips_regfile_mp.sv - multi-port register file with busy scoreboard (option REGFILE_BYPASS_EN)
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int DW      = REG_DW,
  parameter int AW      = REG_AW,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int R0_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_regfile_mp_if.slave    bus
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]     rf_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [NRD*DW-1:0] rd_all;
  logic [NRD-1:0]    rbusy_all;

  // Array writes in port order so the highest port wins on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k] &&
            !((R0_ZERO != 0) && (bus.wa[k*AW +: AW] == AW'(REG_ZERO)))) begin
          rf_q[bus.wa[k*AW +: AW]] <= bus.wd[k*DW +: DW];
        end
      end
    end
  end

  // Scoreboard: writeback clears, allocation sets afterwards so the newer producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k]) begin
          busy_q[bus.wa[k*AW +: AW]] <= 1'b0;
        end
      end
      if (bus.alloc_en &&
          !((R0_ZERO != 0) && (bus.alloc_addr == AW'(REG_ZERO)))) begin
        busy_q[bus.alloc_addr] <= 1'b1;
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] ra_j;
    assign ra_j = bus.ra[j*AW +: AW];

    mips_rf_rdport #(
      .DW      (DW),
      .AW      (AW),
      .NWR     (NWR),
      .R0_ZERO (R0_ZERO)
    ) u_rdport (
      .re        (bus.re[j]),
      .ra        (ra_j),
      .arr_rdata (rf_q[ra_j]),
      .arr_busy  (busy_q[ra_j]),
      .we        (bus.we),
      .wa        (bus.wa),
      .wd        (bus.wd),
      .rd        (rd_all[j*DW +: DW]),
      .rbusy     (rbusy_all[j])
    );
  end

  assign bus.rd       = rd_all;
  assign bus.rbusy    = rbusy_all;
  assign bus.busy_vec = busy_q;

endmodule
